// File: rtl/fib_sampler.sv
// fib_sampler: re-samples an asynchronous Fibonacci value bus, queues each new
// stable value in a small FIFO and exposes FIFO, status and irq over Wishbone.
module fib_sampler #(
  parameter int          WIDTH     = 30,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0100
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [WIDTH-1:0] value_i,
  output logic             irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_s1, r_s2, r_last;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf, r_wrap;
  logic [1:0]       r_ctrl;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_irq;

  logic             w_req, w_sel_stat, w_sel_data, w_sel_ctrl;
  logic             w_empty, w_full, w_cap, w_push, w_pop, w_wr;
  logic [WIDTH-1:0] w_head;
  logic [31:0]      w_status, w_rdata;
  logic             w_unused;

  assign w_req      = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_sel_stat = (wbs_adr_i == ADDR_BASE);
  assign w_sel_data = (wbs_adr_i == ADDR_BASE + 32'h4);
  assign w_sel_ctrl = (wbs_adr_i == ADDR_BASE + 32'h8);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A value is taken once it has been identical in both sync stages and differs
  // from the last value taken; a full FIFO still advances last so the dropped
  // value is not re-captured later.
  assign w_cap  = r_ctrl[0] & (r_s1 == r_s2) & (r_s2 != r_last);
  assign w_push = w_cap & ~w_full;
  assign w_pop  = w_req & ~wbs_we_i & w_sel_data & ~w_empty;
  assign w_wr   = w_req & wbs_we_i & wbs_sel_i[0];

  assign w_head   = w_empty ? '0 : r_mem[r_rptr];
  assign w_status = {20'b0, r_wrap, r_ovf, w_full, w_empty, 8'(r_count)};

  // Read data mux; unmapped addresses read as zero
  always_comb begin
    w_rdata = '0;
    if (w_sel_stat)      w_rdata = w_status;
    else if (w_sel_data) w_rdata = 32'(w_head);
    else if (w_sel_ctrl) w_rdata = {30'b0, r_ctrl};
  end

  assign w_unused = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:12], wbs_dat_i[9:2]};

  // Two-stage resync of the value bus and the last-captured tracker
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_last <= '0;
    end else begin
      r_s1 <= value_i;
      r_s2 <= r_s1;
      if (w_cap) r_last <= r_s2;
    end
  end

  // FIFO storage; contents are don't-care while their slot is not counted
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= r_s2;
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky OVF/WRAP flags (set beats a same-cycle W1C) and the control register
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf  <= 1'b0;
      r_wrap <= 1'b0;
      r_ctrl <= '0;
    end else begin
      if (w_cap && w_full)                             r_ovf <= 1'b1;
      else if (w_wr && w_sel_stat && wbs_dat_i[10])    r_ovf <= 1'b0;
      if (w_cap && (r_s2 < r_last))                    r_wrap <= 1'b1;
      else if (w_wr && w_sel_stat && wbs_dat_i[11])    r_wrap <= 1'b0;
      if (w_wr && w_sel_ctrl)                          r_ctrl <= wbs_dat_i[1:0];
    end
  end

  // Single-cycle ack with data registered alongside it, zero between transfers
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
    end
  end

  // Level interrupt, one cycle behind its causes
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= r_ctrl[1] & (w_full | r_ovf | r_wrap);
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_fib_sampler.sv
// Directed bench for fib_sampler; reads are scoreboarded by a negedge monitor.
module tb_fib_sampler;
  localparam logic [31:0] STAT = 32'h3000_0100;
  localparam logic [31:0] DATA = 32'h3000_0104;
  localparam logic [31:0] CTRL = 32'h3000_0108;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack, irq;
  logic [31:0] dat_o;
  logic [29:0] value = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  fib_sampler dut (
    .wb_clk_i(clk), .reset_n(reset_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .value_i(value), .irq_o(irq)
  );

  // Monitor: every ack retires the oldest expected response
  always @(negedge clk) begin
    if (ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack dat=%h", dat_o);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (dat_o !== e) begin
          errors++;
          $display("FAIL %s got %h want %h", n, dat_o, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, exp);
    end
  endtask

  task automatic wb(input string n, input logic [31:0] a, input logic w,
                    input logic [31:0] d, input logic [31:0] exp);
    bit got;
    exp_q.push_back(w ? 32'h0 : exp);
    name_q.push_back(n);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = 4'h1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s ack_timeout got 0 want 1", n);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic feed(input logic [29:0] v);
    @(negedge clk); value = v;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // 1. reset, then reset asserted in the middle of a read
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; adr = STAT;
    #2 reset_n = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (ack) seen = 1'b1; end
      chk("reset_abort_ack", {31'b0, seen}, 32'h0);
    end
    chk("reset_dat_o", dat_o, 32'h0);
    @(negedge clk); stb = 1'b0; cyc = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    wb("reset_status", STAT, 1'b0, 0, 32'h100);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // 2. capture latency: pushed on 3rd edge after settling
    wb("ctrl_en", CTRL, 1'b1, 32'h1, 0);
    @(negedge clk); value = 30'd1;
    @(negedge clk);
    wb("lat_before", STAT, 1'b0, 0, 32'h100);
    wb("lat_after", STAT, 1'b0, 0, 32'h001);
    wb("lat_data", DATA, 1'b0, 0, 32'h1);
    wb("lat_empty", STAT, 1'b0, 0, 32'h100);

    // 3. sequence with duplicate, from a fresh reset
    value = '0;
    do_reset();
    wb("ctrl_en2", CTRL, 1'b1, 32'h1, 0);
    feed(30'd1); feed(30'd1); feed(30'd2); feed(30'd3); feed(30'd5);
    wb("seq_full", STAT, 1'b0, 0, 32'h204);

    // 4. overflow and irq
    feed(30'd8);
    wb("ovf_status", STAT, 1'b0, 0, 32'h604);
    wb("ctrl_irq", CTRL, 1'b1, 32'h3, 0);
    @(posedge clk); #1;
    chk("ovf_irq_on", {31'b0, irq}, 32'h1);
    wb("ovf_pop1", DATA, 1'b0, 0, 32'h1);
    wb("ovf_w1c", STAT, 1'b1, 32'h400, 0);
    chk("ovf_irq_hold", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    chk("ovf_irq_off", {31'b0, irq}, 32'h0);
    wb("ovf_cleared", STAT, 1'b0, 0, 32'h003);

    // 5. wrap, then glitch rejection
    wb("drain2", DATA, 1'b0, 0, 32'h2);
    wb("drain3", DATA, 1'b0, 0, 32'h3);
    wb("drain5", DATA, 1'b0, 0, 32'h5);
    wb("drained", STAT, 1'b0, 0, 32'h100);
    feed(30'h3FFF_FFFF);
    feed(30'd5);
    wb("wrap_status", STAT, 1'b0, 0, 32'h802);
    chk("wrap_irq", {31'b0, irq}, 32'h1);
    @(negedge clk); value = 30'd7;
    @(negedge clk); value = 30'd5;
    repeat (10) @(negedge clk);
    wb("glitch_status", STAT, 1'b0, 0, 32'h802);

    // 6. pop coinciding with a push at count=2
    @(negedge clk); value = 30'd9;
    @(negedge clk);
    wb("sim_pop", DATA, 1'b0, 0, 32'h3FFF_FFFF);
    wb("sim_count", STAT, 1'b0, 0, 32'h802);
    wb("sim_pop5", DATA, 1'b0, 0, 32'h5);
    wb("sim_pop9", DATA, 1'b0, 0, 32'h9);
    wb("pop_empty", DATA, 1'b0, 0, 32'h0);
    wb("empty_wrap", STAT, 1'b0, 0, 32'h900);
    wb("wrap_w1c", STAT, 1'b1, 32'h800, 0);
    wb("wrap_cleared", STAT, 1'b0, 0, 32'h100);
    @(posedge clk); #1;
    chk("irq_idle", {31'b0, irq}, 32'h0);
    wb("ctrl_read", CTRL, 1'b0, 0, 32'h3);
    wb("unmapped", 32'h3000_010C, 1'b0, 0, 32'h0);

    // enable=0 holds off capture
    wb("ctrl_dis", CTRL, 1'b1, 32'h2, 0);
    feed(30'd11);
    wb("disabled", STAT, 1'b0, 0, 32'h100);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_responses got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
